// File: rtl/fb_bus_write_queue.sv
// Front end of the framebuffer write path. Brings the asynchronous 6502 bus
// into the pixel-clock domain, captures every CPU write into the VRAM window
// and queues {offset, data} in a small FIFO. The VRAM arbiter drains the FIFO
// whenever it grants a slot.
module fb_bus_write_queue #(
   parameter int ADDR_W      = 14,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         Clock,
   input  logic                         Reset_n,
   input  logic                         Phi2,
   input  logic [15:0]                  AddrPhys,
   input  logic [7:0]                   DataIn,
   input  logic                         RW_n,
   input  logic                         AddrSel,
   output logic                         WrValid,
   output logic [ADDR_W-1:0]            WrAddr,
   output logic [7:0]                   WrData,
   input  logic                         WrReady,
   output logic [$clog2(DEPTH+1)-1:0]   Level,
   output logic                         Full,
   output logic                         Overflow,
   input  logic                         OverflowClr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int BUS_W = ADDR_W + 10;   // {addr, data, rw_n, sel}
   localparam int ENT_W = ADDR_W + 8;    // {addr, data}

   // Address bits above the VRAM offset are decoded upstream (AddrSel).
   logic unused_addr_hi;
   assign unused_addr_hi = ^AddrPhys[15:ADDR_W];

   logic [BUS_W-1:0]       bus_in;
   assign bus_in = {AddrPhys[ADDR_W-1:0], DataIn, RW_n, AddrSel};

   logic [SYNC_STAGES-1:0] phi_sync_q, phi_sync_d;
   logic                   phi_p_q, phi_p_d;
   logic [BUS_W-1:0]       dly_q [SYNC_STAGES];
   logic [BUS_W-1:0]       dly_d [SYNC_STAGES];
   logic [BUS_W-1:0]       hold_q, hold_d;
   logic                   phi_s;
   logic [BUS_W-1:0]       bus_dly;

   assign phi_s   = phi_sync_q[SYNC_STAGES-1];
   assign bus_dly = dly_q[SYNC_STAGES-1];

   // Phi2 synchroniser, matching bus delay line, and hold register that
   // freezes the last bus value seen while Phi2 was high.
   always_comb begin
      phi_sync_d = {phi_sync_q[SYNC_STAGES-2:0], Phi2};
      phi_p_d    = phi_s;
      dly_d[0]   = bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         dly_d[i] = dly_q[i-1];
      end
      hold_d = phi_s ? bus_dly : hold_q;
   end

   // Synchroniser and capture registers.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         phi_sync_q <= '0;
         phi_p_q    <= 1'b0;
         hold_q     <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dly_q[i] <= '0;
         end
      end else begin
         phi_sync_q <= phi_sync_d;
         phi_p_q    <= phi_p_d;
         hold_q     <= hold_d;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dly_q[i] <= dly_d[i];
         end
      end
   end

   logic             phi_fall;
   logic             push_req;
   logic [ENT_W-1:0] push_ent;

   // A write into the window is queued on the synchronised Phi2 falling edge.
   assign phi_fall = phi_p_q & ~phi_s;
   assign push_req = phi_fall & ~hold_q[1] & hold_q[0];
   assign push_ent = hold_q[BUS_W-1:2];

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0] after_pop;
   logic [ENT_W-1:0] head_q, head_d;
   logic             ovf_q, ovf_d;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             ovf_set;

   assign full = (level_q == LVL_W'(DEPTH));

   // FIFO control: push/pop arbitration, pointers, level, registered head
   // (holds its last value when the queue runs empty) and sticky overflow.
   always_comb begin
      mem_d     = mem_q;
      pop       = (level_q != '0) && WrReady;
      push_ok   = push_req && (!full || pop);
      ovf_set   = push_req && full && !pop;
      wptr_d    = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d    = pop     ? rptr_q + PTR_W'(1) : rptr_q;
      after_pop = level_q - LVL_W'(pop);
      level_d   = after_pop + LVL_W'(push_ok);
      head_d    = head_q;
      if (push_ok) begin
         mem_d[wptr_q] = push_ent;
      end
      if (level_d != '0) begin
         head_d = (after_pop == '0) ? push_ent : mem_q[rptr_d];
      end
      ovf_d = ovf_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (OverflowClr) begin
         ovf_d = 1'b0;
      end
   end

   // FIFO storage; contents are only read where the level marks them valid.
   always_ff @(posedge Clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   // FIFO state registers.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         head_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         head_q  <= head_d;
         ovf_q   <= ovf_d;
      end
   end

   assign WrValid  = (level_q != '0);
   assign WrAddr   = head_q[ENT_W-1:8];
   assign WrData   = head_q[7:0];
   assign Level    = level_q;
   assign Full     = full;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_fb_bus_write_queue.sv
// Directed bench for fb_bus_write_queue with default parameters.
module tb_fb_bus_write_queue;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        Phi2;
   logic [15:0] AddrPhys;
   logic [7:0]  DataIn;
   logic        RW_n;
   logic        AddrSel;
   logic        WrValid;
   logic [13:0] WrAddr;
   logic [7:0]  WrData;
   logic        WrReady;
   logic [2:0]  Level;
   logic        Full;
   logic        Overflow;
   logic        OverflowClr;

   int errors = 0;
   int checks = 0;
   logic       valid_seen;
   logic [2:0] level_max;

   fb_bus_write_queue #(.ADDR_W(14), .DEPTH(4), .SYNC_STAGES(2)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Phi2(Phi2), .AddrPhys(AddrPhys),
      .DataIn(DataIn), .RW_n(RW_n), .AddrSel(AddrSel), .WrValid(WrValid),
      .WrAddr(WrAddr), .WrData(WrData), .WrReady(WrReady), .Level(Level),
      .Full(Full), .Overflow(Overflow), .OverflowClr(OverflowClr)
   );

   always #5 Clock = ~Clock;

   // One 6502 bus cycle: Phi2 high 4 clocks, low 4 clocks; records any
   // WrValid activity and the peak level while it runs.
   task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d,
                            input logic rw, input logic sel);
      @(negedge Clock);
      AddrPhys = a; DataIn = d; RW_n = rw; AddrSel = sel; Phi2 = 1'b1;
      repeat (4) begin
         @(negedge Clock);
         valid_seen |= WrValid;
         if (Level > level_max) level_max = Level;
      end
      Phi2 = 1'b0;
      repeat (4) begin
         @(negedge Clock);
         valid_seen |= WrValid;
         if (Level > level_max) level_max = Level;
      end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      repeat (3) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clock);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      #1;
      checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", WrValid); end
      checks++; if (Level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", Level); end
      checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", Full); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
      checks++; if (WrAddr !== 14'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", WrAddr); end
      checks++; if (WrData !== 8'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", WrData); end
      repeat (3) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clock);
   endtask

   task automatic test_single();
      int first = 0;
      int pulses = 0;
      WrReady = 1'b1;
      @(negedge Clock);
      AddrPhys = 16'h8001; DataIn = 8'h00; RW_n = 1'b0; AddrSel = 1'b1; Phi2 = 1'b1;
      repeat (4) @(negedge Clock);
      Phi2 = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clock);
         if (WrValid === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = i;
               checks++; if (WrAddr !== 14'h0001) begin errors++; $display("FAIL single_addr got=%h exp=0001", WrAddr); end
               checks++; if (WrData !== 8'h00) begin errors++; $display("FAIL single_data got=%h exp=00", WrData); end
            end
         end
      end
      checks++; if (first < 1 || first > 4) begin errors++; $display("FAIL single_latency got=%0d exp=1..4", first); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
      checks++; if (Level !== 3'd0) begin errors++; $display("FAIL single_level got=%0d exp=0", Level); end
   endtask

   task automatic test_filter();
      WrReady = 1'b0;
      valid_seen = 1'b0;
      level_max = 3'd0;
      cpu_cycle(16'h8001, 8'h55, 1'b1, 1'b1);
      cpu_cycle(16'h4000, 8'h66, 1'b0, 1'b0);
      checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL filter_valid got=%b exp=0", valid_seen); end
      checks++; if (level_max !== 3'd0) begin errors++; $display("FAIL filter_level got=%0d exp=0", level_max); end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      WrReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
         v = 8'h10 + 8'(k);
         cpu_cycle({8'h80, v}, v, 1'b0, 1'b1);
      end
      checks++; if (Level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", Level); end
      checks++; if (Full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", Full); end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
      WrReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         v = 8'h10 + 8'(k);
         checks++;
         if (WrValid !== 1'b1 || WrAddr !== {6'h0, v} || WrData !== v) begin
            errors++;
            $display("FAIL ovf_drain%0d got=%b/%h/%h exp=1/%h/%h", k, WrValid, WrAddr, WrData, {6'h0, v}, v);
         end
         @(negedge Clock);
      end
      checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got=%b exp=0", WrValid); end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", Overflow); end
      WrReady = 1'b0;
      OverflowClr = 1'b1;
      @(negedge Clock);
      OverflowClr = 1'b0;
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", Overflow); end
   endtask

   task automatic test_full_concurrent();
      logic [7:0] v;
      logic [13:0] exp_a [4];
      logic [7:0]  exp_d [4];
      WrReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         v = 8'h20 + 8'(k);
         cpu_cycle({8'h80, 8'(k)}, v, 1'b0, 1'b1);
      end
      checks++; if (Full !== 1'b1) begin errors++; $display("FAIL fullpp_prefull got=%b exp=1", Full); end
      @(negedge Clock);
      AddrPhys = 16'h8020; DataIn = 8'hAA; RW_n = 1'b0; AddrSel = 1'b1; Phi2 = 1'b1;
      repeat (4) @(negedge Clock);
      Phi2 = 1'b0;
      repeat (2) @(negedge Clock);
      WrReady = 1'b1;
      @(negedge Clock);
      WrReady = 1'b0;
      checks++; if (Level !== 3'd4) begin errors++; $display("FAIL fullpp_level got=%0d exp=4", Level); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%b exp=0", Overflow); end
      exp_a[0] = 14'h0001; exp_d[0] = 8'h21;
      exp_a[1] = 14'h0002; exp_d[1] = 8'h22;
      exp_a[2] = 14'h0003; exp_d[2] = 8'h23;
      exp_a[3] = 14'h0020; exp_d[3] = 8'hAA;
      repeat (3) @(negedge Clock);
      WrReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (WrValid !== 1'b1 || WrAddr !== exp_a[k] || WrData !== exp_d[k]) begin
            errors++;
            $display("FAIL fullpp_drain%0d got=%b/%h/%h exp=1/%h/%h", k, WrValid, WrAddr, WrData, exp_a[k], exp_d[k]);
         end
         @(negedge Clock);
      end
      checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got=%b exp=0", WrValid); end
      WrReady = 1'b0;
   endtask

   task automatic test_config();
      WrReady = 1'b0;
      cpu_cycle(16'h80A0, 8'h04, 1'b0, 1'b1);
      cpu_cycle(16'h80A0, 8'h05, 1'b0, 1'b1);
      checks++; if (Level !== 3'd2) begin errors++; $display("FAIL cfg_level got=%0d exp=2", Level); end
      WrReady = 1'b1;
      checks++; if (WrValid !== 1'b1 || WrAddr !== 14'h00A0 || WrData !== 8'h04) begin
         errors++; $display("FAIL cfg_first got=%b/%h/%h exp=1/00a0/04", WrValid, WrAddr, WrData); end
      @(negedge Clock);
      checks++; if (WrValid !== 1'b1 || WrAddr !== 14'h00A0 || WrData !== 8'h05) begin
         errors++; $display("FAIL cfg_second got=%b/%h/%h exp=1/00a0/05", WrValid, WrAddr, WrData); end
      @(negedge Clock);
      WrReady = 1'b0;
      checks++; if (Level !== 3'd0) begin errors++; $display("FAIL cfg_drained got=%0d exp=0", Level); end
   endtask

   task automatic test_reset_mid();
      WrReady = 1'b0;
      cpu_cycle(16'h8030, 8'h31, 1'b0, 1'b1);
      cpu_cycle(16'h8031, 8'h32, 1'b0, 1'b1);
      checks++; if (Level !== 3'd2) begin errors++; $display("FAIL rstmid_pre got=%0d exp=2", Level); end
      #2;
      Reset_n = 1'b0;
      #1;
      checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", WrValid); end
      checks++; if (Level !== 3'd0) begin errors++; $display("FAIL rstmid_level got=%0d exp=0", Level); end
      @(negedge Clock);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clock);
      cpu_cycle(16'h8001, 8'h7F, 1'b0, 1'b1);
      checks++; if (Level !== 3'd1 || WrAddr !== 14'h0001 || WrData !== 8'h7F) begin
         errors++; $display("FAIL rstmid_after got=%0d/%h/%h exp=1/0001/7f", Level, WrAddr, WrData); end
   endtask

   initial begin
      Reset_n = 1'b0; Phi2 = 1'b0; AddrPhys = 16'h0; DataIn = 8'h0;
      RW_n = 1'b1; AddrSel = 1'b0; WrReady = 1'b0; OverflowClr = 1'b0;
      valid_seen = 1'b0; level_max = 3'd0;
      repeat (2) @(negedge Clock);
      test_reset();
      test_single();
      test_filter();
      test_overflow();
      test_full_concurrent();
      test_config();
      test_reset_mid();
      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
